// File: rtl/fifo_rr_pop_arbiter.sv
// Round-robin pop arbiter for four source FIFOs: issues one-hot pops, forwards
// the popped word with its source index and keeps per-source delivery counters.
module fifo_rr_pop_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 6,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_SRC-1:0]    fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data0,
  input  logic [DATA_WIDTH-1:0] fifo_data1,
  input  logic [DATA_WIDTH-1:0] fifo_data2,
  input  logic [DATA_WIDTH-1:0] fifo_data3,
  input  logic                  pausa_dest,
  output logic [NUM_SRC-1:0]    pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [1:0]            src_out,
  output logic                  busy,
  output logic                  err_pop_empty,
  input  logic [1:0]            cnt_sel,
  output logic [CNT_WIDTH-1:0]  cnt_out
);

  typedef enum logic [1:0] {IDLE, GRANT, PAUSED} state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [1:0]            r_last;
  logic [NUM_SRC-1:0]    r_popPrev;
  logic [DATA_WIDTH-1:0] r_dataOut;
  logic [1:0]            r_srcOut;
  logic                  r_validOut;
  logic                  r_errPopEmpty;
  logic [CNT_WIDTH-1:0]  r_cnt [NUM_SRC];

  logic [NUM_SRC-1:0]    w_req;
  logic [1:0]            w_grantIdx;
  logic                  w_grantFound;
  logic [NUM_SRC-1:0]    w_pop;
  logic [DATA_WIDTH-1:0] w_grantData;

  // A source popped last cycle still shows its stale (pre-pop) empty flag, so it sits out one cycle.
  assign w_req = ~fifo_empty & ~r_popPrev;

  always_comb begin
    w_grantIdx   = 2'd0;
    w_grantFound = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      if (!w_grantFound && w_req[2'(r_last + 2'(k))]) begin
        w_grantIdx   = 2'(r_last + 2'(k));
        w_grantFound = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE, GRANT: begin
        if (pausa_dest)        w_nextState = PAUSED;
        else if (w_grantFound) w_nextState = GRANT;
        else                   w_nextState = IDLE;
      end
      PAUSED: begin
        if (!pausa_dest) w_nextState = w_grantFound ? GRANT : IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // The release cycle out of PAUSED never pops; the first post-pause pop comes from GRANT.
  always_comb begin
    w_pop = '0;
    if (!reset && !pausa_dest && w_grantFound && (r_state == IDLE || r_state == GRANT)) begin
      w_pop[w_grantIdx] = 1'b1;
    end
  end

  always_comb begin
    case (w_grantIdx)
      2'd0:    w_grantData = fifo_data0;
      2'd1:    w_grantData = fifo_data1;
      2'd2:    w_grantData = fifo_data2;
      default: w_grantData = fifo_data3;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last        <= 2'd3;
      r_popPrev     <= '0;
      r_dataOut     <= '0;
      r_srcOut      <= 2'd0;
      r_validOut    <= 1'b0;
      r_errPopEmpty <= 1'b0;
      for (int i = 0; i < NUM_SRC; i++) r_cnt[i] <= '0;
    end else begin
      r_popPrev     <= w_pop;
      r_validOut    <= |w_pop;
      r_errPopEmpty <= r_errPopEmpty | (|(w_pop & fifo_empty));
      if (|w_pop) begin
        r_last    <= w_grantIdx;
        r_dataOut <= w_grantData;
        r_srcOut  <= w_grantIdx;
      end
      if (r_validOut) r_cnt[r_srcOut] <= r_cnt[r_srcOut] + 1'b1;
    end
  end

  // Reset in the cycle after a pop suppresses that word's valid strobe.
  assign valid_out     = r_validOut & ~reset;
  assign pop           = w_pop;
  assign data_out      = r_dataOut;
  assign src_out       = r_srcOut;
  assign busy          = |r_popPrev;
  assign err_pop_empty = r_errPopEmpty;
  assign cnt_out       = r_cnt[cnt_sel];

endmodule

// File: tb/tb_fifo_rr_pop_arbiter.sv
// Directed bench for fifo_rr_pop_arbiter: rotation, single requester, pause,
// mid-flight reset and counter wrap, with hand-computed expectations.
module tb_fifo_rr_pop_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] fifoEmpty = 4'hF;
  logic [5:0] fifoData0 = 6'h10;
  logic [5:0] fifoData1 = 6'h11;
  logic [5:0] fifoData2 = 6'h12;
  logic [5:0] fifoData3 = 6'h13;
  logic       pausaDest = 1'b0;
  logic [3:0] pop;
  logic [5:0] dataOut;
  logic       validOut;
  logic [1:0] srcOut;
  logic       busy;
  logic       errPopEmpty;
  logic [1:0] cntSel = 2'd0;
  logic [7:0] cntOut;

  int compared = 0;
  int mismatched = 0;
  int popCount;
  int validCount;
  int cycles;

  fifo_rr_pop_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .fifo_empty   (fifoEmpty),
    .fifo_data0   (fifoData0),
    .fifo_data1   (fifoData1),
    .fifo_data2   (fifoData2),
    .fifo_data3   (fifoData3),
    .pausa_dest   (pausaDest),
    .pop          (pop),
    .data_out     (dataOut),
    .valid_out    (validOut),
    .src_out      (srcOut),
    .busy         (busy),
    .err_pop_empty(errPopEmpty),
    .cnt_sel      (cntSel),
    .cnt_out      (cntOut)
  );

  always #5 clk = ~clk;

  // Drive one cycle's inputs just after the rising edge, return at the falling edge.
  task automatic applyStimulus(input logic rst, input logic [3:0] empty, input logic pausa);
    @(posedge clk);
    #1;
    reset     = rst;
    fifoEmpty = empty;
    pausaDest = pausa;
    #4;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkCnt(input string tag, input logic [1:0] sel, input logic [7:0] expected);
    cntSel = sel;
    #1;
    checkOutput(tag, cntOut, expected);
  endtask

  initial begin
    // Reset state
    applyStimulus(1'b1, 4'hF, 1'b0);
    applyStimulus(1'b1, 4'hF, 1'b0);
    checkOutput("rstPop", pop, 4'b0000);
    checkOutput("rstValid", validOut, 1'b0);
    checkOutput("rstBusy", busy, 1'b0);
    checkOutput("rstErr", errPopEmpty, 1'b0);
    for (int s = 0; s < 4; s++) checkCnt("rstCnt", 2'(s), 8'd0);

    // Full rotation with all sources non-empty
    applyStimulus(1'b0, 4'b0000, 1'b0);
    checkOutput("rotPop0", pop, 4'b0001);
    checkOutput("rotValid0", validOut, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    checkOutput("rotPop1", pop, 4'b0010);
    checkOutput("rotValid1", validOut, 1'b1);
    checkOutput("rotData1", dataOut, 6'h10);
    checkOutput("rotSrc1", srcOut, 2'd0);
    checkOutput("rotBusy1", busy, 1'b1);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    checkOutput("rotPop2", pop, 4'b0100);
    checkOutput("rotData2", dataOut, 6'h11);
    checkOutput("rotSrc2", srcOut, 2'd1);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    checkOutput("rotPop3", pop, 4'b1000);
    checkOutput("rotData3", dataOut, 6'h12);
    checkOutput("rotSrc3", srcOut, 2'd2);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    checkOutput("rotPop4", pop, 4'b0001);
    checkOutput("rotData4", dataOut, 6'h13);
    checkOutput("rotSrc4", srcOut, 2'd3);
    applyStimulus(1'b0, 4'hF, 1'b0);
    checkOutput("rotPop5", pop, 4'b0000);
    checkOutput("rotData5", dataOut, 6'h10);
    checkOutput("rotSrc5", srcOut, 2'd0);
    applyStimulus(1'b0, 4'hF, 1'b0);
    checkOutput("rotIdleValid", validOut, 1'b0);
    checkOutput("rotIdleBusy", busy, 1'b0);
    checkCnt("rotCnt0", 2'd0, 8'd2);
    checkCnt("rotCnt3", 2'd3, 8'd1);

    // Single requester alternates because of the block rule
    applyStimulus(1'b1, 4'hF, 1'b0);
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b0, 4'b1011, 1'b0);
      checkOutput("solePop", pop, (c % 2 == 0) ? 4'b0100 : 4'b0000);
      if (c % 2 == 1) checkOutput("soleSrc", srcOut, 2'd2);
    end
    applyStimulus(1'b0, 4'hF, 1'b0);
    checkCnt("soleCnt2", 2'd2, 8'd3);

    // Pause: in-flight word drains, rotation resumes after source 1
    applyStimulus(1'b1, 4'hF, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    checkOutput("pausePop0", pop, 4'b0001);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    checkOutput("pausePop1", pop, 4'b0010);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    checkOutput("pauseHeldPop", pop, 4'b0000);
    checkOutput("pauseDrainValid", validOut, 1'b1);
    checkOutput("pauseDrainSrc", srcOut, 2'd1);
    checkOutput("pauseDrainData", dataOut, 6'h11);
    applyStimulus(1'b0, 4'b0000, 1'b1);
    checkOutput("pauseHeldPop2", pop, 4'b0000);
    checkOutput("pauseValidGone", validOut, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    checkOutput("pauseReleasePop", pop, 4'b0000);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    checkOutput("pauseResumePop", pop, 4'b0100);

    // Reset right after a pop discards the word
    applyStimulus(1'b1, 4'b0000, 1'b0);
    checkOutput("midRstValid", validOut, 1'b0);
    checkOutput("midRstPop", pop, 4'b0000);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    checkOutput("postRstValid", validOut, 1'b0);
    checkOutput("postRstPop", pop, 4'b0001);

    // 256 words from source 0 wrap its counter
    applyStimulus(1'b1, 4'hF, 1'b0);
    popCount = 0;
    validCount = 0;
    cycles = 0;
    while (popCount < 256 && cycles < 600) begin
      applyStimulus(1'b0, 4'b1110, 1'b0);
      if (pop[0]) popCount++;
      if (validOut && srcOut == 2'd0) validCount++;
      cycles++;
    end
    checkOutput("wrapPopCount", popCount, 256);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 4'hF, 1'b0);
      if (validOut && srcOut == 2'd0) validCount++;
    end
    checkOutput("wrapValidCount", validCount, 256);
    checkCnt("wrapCnt0", 2'd0, 8'd0);
    checkOutput("errSticky", errPopEmpty, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
